// File: rtl/mips_commit_checker_pkg.sv
// Purpose : shared state encodings, defaults and helpers for the MIPS commit checker.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package mips_commit_checker_pkg;

    // Checker FSM encoding; fixed 2-bit values so software/FPGA probes can decode them.
    typedef enum logic [1:0] {
        CHK_IDLE  = 2'd0,
        CHK_RUN   = 2'd1,
        CHK_CHECK = 2'd2,
        CHK_DONE  = 2'd3
    } chk_state_t;

    // Default run length matching the reference MIPS test program.
    localparam int CHK_CYCLE_LIMIT = 90;
    localparam int CHK_NUM_REGS    = 32;

    // Index range test done on ints so callers need not match vector widths.
    function automatic bit idx_in_range(input int idx, input int num);
        return (idx >= 0) && (idx < num);
    endfunction

endpackage

// File: rtl/mips_commit_checker_shadow_regs.sv
// Purpose : NUM_REGS x DATA_WIDTH register table with one flag bit per entry
//           (written bit for the shadow copy, check mask for the expected table).
// Latency : write visible on the read port 1 cycle after the write edge; read is combinational.
// Backpressure: none; writes are always accepted, out-of-range indices are dropped.
// Ports   : clk/reset; clear (sync, wipes data+flags); we/waddr/wdata/wflag write port;
//           raddr -> rdata/rflag read port.
module mips_commit_checker_shadow_regs
    import mips_commit_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wflag,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rflag
);

    logic [DATA_WIDTH-1:0] mem [NUM_REGS];
    logic [NUM_REGS-1:0]   flag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            flag <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            flag <= '0;
        end else if (we && idx_in_range(int'(waddr), NUM_REGS)) begin
            mem[waddr]  <= wdata;
            flag[waddr] <= wflag;
        end
    end

    // Out-of-range read indices return an empty entry rather than aliasing.
    always_comb begin
        rdata = '0;
        rflag = 1'b0;
        if (idx_in_range(int'(raddr), NUM_REGS)) begin
            rdata = mem[raddr];
            rflag = flag[raddr];
        end
    end

endmodule

// File: rtl/mips_commit_checker.sv
// Purpose : snoops MIPS writeback into a shadow register file, then scans it against a
//           preloaded expected table and reports pass / fail_count / first_fail.
// Latency : RUN for CYCLE_LIMIT cycles (or until stop), then NUM_REGS CHECK cycles -> done.
// Backpressure: none; WB traffic is observed only, start/stop/exp_we outside their states drop.
// Ports   : clk, reset (async active-low); start/stop run control; wb_we/wb_addr/wb_data snoop;
//           exp_we/exp_idx/exp_data/exp_check table load; busy/done/pass/fail_count/
//           first_fail/cycle_count status.
module mips_commit_checker
    import mips_commit_checker_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int NUM_REGS      = CHK_NUM_REGS,
    parameter int CYCLE_LIMIT   = CHK_CYCLE_LIMIT,
    parameter int CNT_WIDTH     = 16,
    parameter int REQUIRE_WRITE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  exp_we,
    input  logic [ADDR_WIDTH-1:0] exp_idx,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic                  exp_check,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam logic [CNT_WIDTH-1:0]  LAST_CYC = CNT_WIDTH'(CYCLE_LIMIT - 1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   FAIL_ONE = 1;

    chk_state_t state, state_nxt;

    logic                  idle_or_done;
    logic                  start_acc;
    logic                  exp_acc;
    logic                  shadow_we;
    logic                  run_last;
    logic [ADDR_WIDTH-1:0] scan_idx;

    logic [DATA_WIDTH-1:0] sh_data;
    logic                  sh_written;
    logic [DATA_WIDTH-1:0] ex_data;
    logic                  ex_mask;
    logic                  mismatch;
    logic                  write_missing;
    logic                  entry_fail;

    assign idle_or_done = (state == CHK_IDLE) || (state == CHK_DONE);
    assign start_acc    = idle_or_done && start;
    assign exp_acc      = idle_or_done && exp_we;
    // $0 is hard-wired zero in the core, so writes to it are never shadowed.
    assign shadow_we    = (state == CHK_RUN) && wb_we && (wb_addr != '0);
    assign run_last     = stop || (cycle_count == LAST_CYC);

    // Shadow of the architectural registers; flag = written during this run.
    mips_commit_checker_shadow_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_shadow (
        .clk   (clk),
        .reset (reset),
        .clear (start_acc),
        .we    (shadow_we),
        .waddr (wb_addr),
        .wdata (wb_data),
        .wflag (1'b1),
        .raddr (scan_idx),
        .rdata (sh_data),
        .rflag (sh_written)
    );

    // Expected table; flag = check mask. Survives start, only reset wipes it.
    mips_commit_checker_shadow_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_expected (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .we    (exp_acc),
        .waddr (exp_idx),
        .wdata (exp_data),
        .wflag (exp_check),
        .raddr (scan_idx),
        .rdata (ex_data),
        .rflag (ex_mask)
    );

    // Entry compare. Index 0 is checked against the constant 0 and never needs a write.
    always_comb begin
        mismatch      = 1'b0;
        write_missing = 1'b0;
        if (scan_idx == '0) begin
            mismatch = (ex_data != '0);
        end else begin
            mismatch      = (sh_data != ex_data);
            write_missing = (REQUIRE_WRITE != 0) && !sh_written;
        end
        entry_fail = ex_mask && (mismatch || write_missing);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= CHK_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            CHK_IDLE:  if (start) state_nxt = CHK_RUN;
            CHK_RUN:   if (run_last) state_nxt = CHK_CHECK;
            CHK_CHECK: if (scan_idx == LAST_IDX) state_nxt = CHK_DONE;
            CHK_DONE:  if (start) state_nxt = CHK_RUN;
            default:   state_nxt = CHK_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state == CHK_RUN) || (state == CHK_CHECK);
        done = (state == CHK_DONE);
        pass = (state == CHK_DONE) && (fail_count == '0);
    end

    // Counters and scan pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
            fail_count  <= '0;
            first_fail  <= '0;
            scan_idx    <= '0;
        end else if (start_acc) begin
            cycle_count <= '0;
            fail_count  <= '0;
            first_fail  <= '0;
            scan_idx    <= '0;
        end else if (state == CHK_RUN) begin
            cycle_count <= cycle_count + CNT_ONE;
            scan_idx    <= '0;
        end else if (state == CHK_CHECK) begin
            if (entry_fail) begin
                fail_count <= fail_count + FAIL_ONE;
                // Scan ascends, so the first recorded fail is the lowest index.
                if (fail_count == '0) begin
                    first_fail <= scan_idx;
                end
            end
            if (scan_idx != LAST_IDX) begin
                scan_idx <= scan_idx + IDX_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mips_commit_checker.sv
// Purpose : directed bench for mips_commit_checker; one instance requires writes, one does not.
// Latency : inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_mips_commit_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, wb_we, exp_we, exp_check;
    logic [4:0]  wb_addr, exp_idx;
    logic [31:0] wb_data, exp_data;

    logic        busy, done, pass;
    logic [5:0]  fail_count;
    logic [4:0]  first_fail;
    logic [15:0] cycle_count;

    logic        busy_nw, done_nw, pass_nw;
    logic [5:0]  fail_count_nw;
    logic [4:0]  first_fail_nw;
    logic [15:0] cycle_count_nw;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;
    int s_edge;

    always #5 clk = ~clk;

    mips_commit_checker #(.REQUIRE_WRITE(1)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .exp_check(exp_check),
        .busy(busy), .done(done), .pass(pass), .fail_count(fail_count),
        .first_fail(first_fail), .cycle_count(cycle_count)
    );

    mips_commit_checker #(.REQUIRE_WRITE(0)) dut_nw (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .exp_we(exp_we), .exp_idx(exp_idx), .exp_data(exp_data), .exp_check(exp_check),
        .busy(busy_nw), .done(done_nw), .pass(pass_nw), .fail_count(fail_count_nw),
        .first_fail(first_fail_nw), .cycle_count(cycle_count_nw)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic load(input logic [4:0] idx, input logic [31:0] data, input logic m);
        exp_we = 1'b1; exp_idx = idx; exp_data = data; exp_check = m;
        tick();
        exp_we = 1'b0;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_we = 1'b1; wb_addr = addr; wb_data = data;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        s_edge = cyc;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        if (!done) chk("done_timeout", {63'd0, done}, 64'd1);
    endtask

    task automatic write_good_set(input logic with7);
        wb(5'd3, 32'd0);
        wb(5'd4, 32'd30);
        wb(5'd5, 32'd30);
        wb(5'd6, 32'hFFFF_FFE1);
        if (with7) wb(5'd7, 32'd1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        exp_we = 1'b0; exp_idx = '0; exp_data = '0; exp_check = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_pass", {63'd0, pass}, 64'd0);
        chk("rst_fail_count", {58'd0, fail_count}, 64'd0);
        chk("rst_first_fail", {59'd0, first_fail}, 64'd0);
        chk("rst_cycle_count", {48'd0, cycle_count}, 64'd0);
        reset = 1'b1;
        tick();

        // 1: full-length run, last write lands in the final RUN cycle
        load(5'd3, 32'd0, 1'b1);
        load(5'd4, 32'd30, 1'b1);
        load(5'd5, 32'd30, 1'b1);
        load(5'd6, 32'hFFFF_FFE1, 1'b1);
        load(5'd7, 32'd1, 1'b1);
        load(5'd8, 32'd80, 1'b1);
        start_run();
        chk("t1_busy_after_start", {63'd0, busy}, 64'd1);
        write_good_set(1'b1);
        while (cyc < t0 + 89) tick();
        wb(5'd8, 32'd80);
        chk("t1_busy_in_check", {63'd0, busy}, 64'd1);
        wait_done(200);
        chk("t1_done_latency", 64'(cyc - t0), 64'd122);
        chk("t1_cycle_count", {48'd0, cycle_count}, 64'd90);
        chk("t1_pass", {63'd0, pass}, 64'd1);
        chk("t1_fail_count", {58'd0, fail_count}, 64'd0);
        chk("t1_busy_done", {63'd0, busy}, 64'd0);
        chk("t1_nw_pass", {63'd0, pass_nw}, 64'd1);

        // 2: $8 written as 81
        start_run();
        write_good_set(1'b1);
        wb(5'd8, 32'd81);
        stop_run();
        wait_done(100);
        chk("t2_pass", {63'd0, pass}, 64'd0);
        chk("t2_fail_count", {58'd0, fail_count}, 64'd1);
        chk("t2_first_fail", {59'd0, first_fail}, 64'd8);
        chk("t2_nw_fail_count", {58'd0, fail_count_nw}, 64'd1);

        // 3: $7 expected 0, masked, never written
        load(5'd7, 32'd0, 1'b1);
        start_run();
        write_good_set(1'b0);
        wb(5'd8, 32'd80);
        stop_run();
        wait_done(100);
        chk("t3_fail_count", {58'd0, fail_count}, 64'd1);
        chk("t3_first_fail", {59'd0, first_fail}, 64'd7);
        chk("t3_nw_pass", {63'd0, pass_nw}, 64'd1);
        chk("t3_nw_fail_count", {58'd0, fail_count_nw}, 64'd0);

        // 4: stop in RUN cycle 10, write to $0 ignored
        load(5'd0, 32'd0, 1'b1);
        start_run();
        wb(5'd0, 32'd5);
        write_good_set(1'b0);
        wb(5'd7, 32'd0);
        wb(5'd8, 32'd80);
        while (cyc < t0 + 10) tick();
        stop_run();
        chk("t4_cycle_count_at_stop", {48'd0, cycle_count}, 64'd11);
        chk("t4_busy_in_check", {63'd0, busy}, 64'd1);
        wait_done(100);
        chk("t4_done_latency", 64'(cyc - s_edge), 64'd32);
        chk("t4_cycle_count_held", {48'd0, cycle_count}, 64'd11);
        chk("t4_pass", {63'd0, pass}, 64'd1);
        chk("t4_nw_pass", {63'd0, pass_nw}, 64'd1);

        // 5: exp_we in RUN dropped, start in CHECK ignored
        start_run();
        wb(5'd0, 32'd5);
        write_good_set(1'b0);
        wb(5'd7, 32'd0);
        wb(5'd8, 32'd80);
        load(5'd4, 32'd99, 1'b1);
        stop_run();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        chk("t5_done_latency", 64'(cyc - s_edge), 64'd32);
        chk("t5_pass", {63'd0, pass}, 64'd1);
        chk("t5_fail_count", {58'd0, fail_count}, 64'd0);
        chk("t5_nw_pass", {63'd0, pass_nw}, 64'd1);

        // 6: reset mid-CHECK after idx 0..4 have been scanned with no writes
        start_run();
        stop_run();
        repeat (5) tick();
        chk("t6_mid_fail_count", {58'd0, fail_count}, 64'd2);
        chk("t6_mid_first_fail", {59'd0, first_fail}, 64'd3);
        chk("t6_mid_nw_first_fail", {59'd0, first_fail_nw}, 64'd4);
        reset = 1'b0;
        #1;
        chk("t6_rst_busy", {63'd0, busy}, 64'd0);
        chk("t6_rst_done", {63'd0, done}, 64'd0);
        chk("t6_rst_pass", {63'd0, pass}, 64'd0);
        chk("t6_rst_fail_count", {58'd0, fail_count}, 64'd0);
        chk("t6_rst_first_fail", {59'd0, first_fail}, 64'd0);
        chk("t6_rst_cycle_count", {48'd0, cycle_count}, 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Table was wiped: an empty run passes
        start_run();
        stop_run();
        wait_done(100);
        chk("t6_empty_pass", {63'd0, pass}, 64'd1);

        // start and exp_we together in DONE: the load counts for this run
        start = 1'b1;
        exp_we = 1'b1; exp_idx = 5'd5; exp_data = 32'd30; exp_check = 1'b1;
        tick();
        start = 1'b0;
        exp_we = 1'b0;
        stop_run();
        wait_done(100);
        chk("t6_reload_fail_count", {58'd0, fail_count}, 64'd1);
        chk("t6_reload_first_fail", {59'd0, first_fail}, 64'd5);
        chk("t6_reload_nw_first_fail", {59'd0, first_fail_nw}, 64'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
